// File: rtl/io_seq_pkg.sv
// Shared definitions for the IO strobe sequencer.
//   seq_state_e            : sequencer states (IDLE, SETUP, STROBE, HOLD)
//   DEFAULT_SETUP_CYCLES   : default select-to-strobe setup time in cycles
//   DEFAULT_TIMEOUT_CYCLES : default ready-wait limit after minimum strobe width
//   CNT_W                  : width of the shared phase counter
package io_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } seq_state_e;

  localparam int DEFAULT_SETUP_CYCLES   = 1;
  localparam int DEFAULT_TIMEOUT_CYCLES = 15;
  localparam int CNT_W                  = 8;

endpackage

// File: rtl/io_seq_counter.sv
// Loadable down-counter shared by the setup, wait-state and timeout phases.
//   clock      : rising-edge clock
//   clear_n    : asynchronous active-low clear (count -> 0)
//   load       : load load_value (has priority over dec)
//   load_value : value to load
//   dec        : decrement by one, saturating at zero
//   zero       : count is zero
module io_seq_counter
  import io_seq_pkg::*;
(
  input  logic             clock,
  input  logic             clear_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/io_strobe_sequencer.sv
// IO strobe sequencer: runs one select/strobe/hold access per accepted request
// towards a 2-to-4 decoded device bus.
//   clock, reset_n  : clock and asynchronous active-low reset
//   req             : access request, sampled in IDLE
//   dev, write      : target device and direction, captured on acceptance
//   wait_states     : minimum extra strobe cycles, captured on acceptance
//   ready           : device ready, sampled once minimum strobe width is met
//   sel             : device select (decoder sel)
//   strobe_n        : active-low strobe (decoder enable_n)
//   write_n         : active-low write qualifier
//   busy            : access in progress
//   ack, timeout    : one-cycle completion pulses during HOLD
module io_strobe_sequencer
  import io_seq_pkg::*;
#(
  parameter int SETUP_CYCLES   = DEFAULT_SETUP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req,
  input  logic [1:0] dev,
  input  logic       write,
  input  logic [3:0] wait_states,
  input  logic       ready,
  output logic [1:0] sel,
  output logic       strobe_n,
  output logic       write_n,
  output logic       busy,
  output logic       ack,
  output logic       timeout
);

  seq_state_e       state, state_next;
  logic             wait_phase, wait_phase_next;
  logic [3:0]       ws_q;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_value;
  logic             accept, ack_next, timeout_next;

  io_seq_counter u_counter (
    .clock      (clock),
    .clear_n    (reset_n),
    .load       (cnt_load),
    .load_value (cnt_value),
    .dec        (cnt_dec),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      wait_phase <= 1'b0;
    end else begin
      state      <= state_next;
      wait_phase <= wait_phase_next;
    end
  end

  // STROBE runs in two phases: the minimum-width phase (counter holds the
  // remaining wait states) and the ready-wait phase (counter holds the
  // remaining timeout budget). ready is honoured whenever the counter has
  // run out in the first phase, or on any cycle of the second phase.
  always_comb begin
    state_next      = state;
    wait_phase_next = wait_phase;
    cnt_load        = 1'b0;
    cnt_dec         = 1'b0;
    cnt_value       = '0;
    accept          = 1'b0;
    ack_next        = 1'b0;
    timeout_next    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept     = 1'b1;
          state_next = SETUP;
          cnt_load   = 1'b1;
          cnt_value  = CNT_W'(SETUP_CYCLES - 1);
        end
      end
      SETUP: begin
        if (cnt_zero) begin
          state_next      = STROBE;
          wait_phase_next = 1'b0;
          cnt_load        = 1'b1;
          cnt_value       = CNT_W'(ws_q);
        end else begin
          cnt_dec = 1'b1;
        end
      end
      STROBE: begin
        if (wait_phase || cnt_zero) begin
          if (ready) begin
            state_next = HOLD;
            ack_next   = 1'b1;
          end else if (!wait_phase) begin
            wait_phase_next = 1'b1;
            cnt_load        = 1'b1;
            cnt_value       = CNT_W'(TIMEOUT_CYCLES - 1);
          end else if (cnt_zero) begin
            state_next   = HOLD;
            timeout_next = 1'b1;
          end else begin
            cnt_dec = 1'b1;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      HOLD: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the
  // state they describe; sel/write_n only ever load on acceptance, which
  // keeps them frozen for the whole access and through the following IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel      <= '0;
      write_n  <= 1'b1;
      ws_q     <= '0;
      strobe_n <= 1'b1;
      busy     <= 1'b0;
      ack      <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      if (accept) begin
        sel     <= dev;
        write_n <= ~write;
        ws_q    <= wait_states;
      end
      strobe_n <= (state_next != STROBE);
      busy     <= (state_next != IDLE);
      ack      <= ack_next;
      timeout  <= timeout_next;
    end
  end

endmodule

// File: doc/io_strobe_sequencer.md
IO_STROBE_SEQUENCER -- requirements
Module: io_strobe_sequencer

Interface
REQ-001 Parameter SETUP_CYCLES, default 1: cycles the select lines are stable before strobe; legal range 1..15.
REQ-002 Parameter TIMEOUT_CYCLES, default 15: ready-wait limit after minimum strobe width; legal range 1..255.
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  access request, level-sampled in IDLE.
REQ-006 dev  input  2  target device index, captured on acceptance.
REQ-007 write  input  1  access direction, captured on acceptance.
REQ-008 wait_states  input  4  minimum extra strobe cycles, captured on acceptance.
REQ-009 ready  input  1  device ready, sampled only in STROBE.
REQ-010 sel  output  2  device select; drives sel of a downstream 2-to-4 decoder.
REQ-011 strobe_n  output  1  active-low strobe; drives that decoder's enable_n.
REQ-012 write_n  output  1  active-low write qualifier for the current access.
REQ-013 busy  output  1  high from the cycle after acceptance until return to IDLE.
REQ-014 ack  output  1  one-cycle pulse: access completed with ready.
REQ-015 timeout  output  1  one-cycle pulse: access aborted by timeout.

Function
REQ-016 States SHALL be IDLE, SETUP, STROBE, HOLD; all outputs registered.
REQ-017 IDLE: req=1 at an edge SHALL capture dev/write/wait_states and enter SETUP; busy=1 from SETUP onward.
REQ-018 sel and write_n SHALL equal captured values in SETUP, STROBE and HOLD; in IDLE they hold last values.
REQ-019 SETUP SHALL last exactly SETUP_CYCLES cycles with strobe_n=1, then enter STROBE.
REQ-020 STROBE: strobe_n=0 for at least wait_states+1 cycles; ready sampled only from the cycle at which that minimum is met.
REQ-021 ready=1 sampled at a qualifying STROBE edge SHALL enter HOLD with ack=1 during the HOLD cycle.
REQ-022 If ready stays 0 for TIMEOUT_CYCLES qualifying cycles, SHALL enter HOLD with timeout=1 during the HOLD cycle; ack stays 0.
REQ-023 ack and timeout SHALL never both be 1; each pulses exactly once per accepted access.
REQ-024 HOLD SHALL last one cycle with strobe_n=1 and sel held, then enter IDLE with busy=0.
REQ-025 req while busy=1 SHALL be ignored; req held high through HOLD SHALL be accepted at the first IDLE edge (one idle cycle between accesses minimum).
REQ-026 Changes to dev/write/wait_states after acceptance SHALL not affect the current access.
REQ-027 Minimum latency (SETUP_CYCLES=1, wait_states=0, ready=1): accepting edge at cycle 0, ack high in cycle 3, busy low in cycle 4.
REQ-028 strobe_n SHALL never glitch low outside STROBE; sel SHALL never change while strobe_n=0.

Reset
REQ-029 reset_n=0 SHALL immediately force IDLE, sel=0, strobe_n=1, write_n=1, busy=0, ack=0, timeout=0, counters=0, regardless of state.
REQ-030 Reset mid-access SHALL abort without ack or timeout pulse; first acceptance possible at the first edge after reset_n rises.

Structure
REQ-031 State enum typedef and default constants for SETUP_CYCLES and TIMEOUT_CYCLES SHALL live in shared package io_seq_pkg.
REQ-032 Cycle counting SHALL use one sub-module io_seq_counter (loadable 8-bit down-counter, async active-low clear, zero flag), reused for setup, wait-state and timeout phases.

Verification
REQ-033 Defaults, req=1 dev=2 write=1 wait_states=0 ready=1 -> sel=2 from cycle 1, strobe_n=0 only in cycle 2, write_n=0, ack in cycle 3, busy low in cycle 4.
REQ-034 wait_states=3, ready=1 throughout -> strobe_n low exactly 4 cycles, then ack.
REQ-035 wait_states=0, ready=0 always -> strobe_n low 1+15 cycles, timeout pulse, no ack.
REQ-036 Back-to-back req held high, dev 1 then 3 -> one IDLE cycle between HOLD and next SETUP; sel never changes while strobe_n=0.
REQ-037 reset_n pulsed low during STROBE -> strobe_n=1 and busy=0 asynchronously, no ack/timeout; next req accepted normally.
REQ-038 dev changed to 0 during STROBE of a dev=3 access -> sel remains 3 until IDLE.
